// File: rtl/riscv_defines.sv
// Shared core defines: hardware-loop write-enable bit positions.
package riscv_defines;

    localparam int HWLP_WE_W     = 3;
    localparam int HWLP_WE_START = 0;
    localparam int HWLP_WE_END   = 1;
    localparam int HWLP_WE_CNT   = 2;

    localparam logic [31:0] HWLP_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/riscv_hwloop_reg_slot.sv
// One hardware-loop register set: start, end, counter and the
// "decrement still in flight in ID" flag.
// Build option: HWLP_SATURATE_EN makes a decrement at 0 hold the counter at 0
// instead of wrapping to all ones.
module riscv_hwloop_reg_slot
    import riscv_defines::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_start_i,
    input  logic        we_end_i,
    input  logic        we_cnt_i,
    input  logic [31:0] start_data_i,
    input  logic [31:0] end_data_i,
    input  logic [31:0] cnt_data_i,
    input  logic        dec_i,
    input  logic        id_valid_i,
    output logic [31:0] start_o,
    output logic [31:0] end_o,
    output logic [31:0] cnt_o,
    output logic        dec_id_o
);

    logic [31:0] start_q, start_d;
    logic [31:0] end_q,   end_d;
    logic [31:0] cnt_q,   cnt_d;
    logic        dec_id_q, dec_id_d;
    logic [31:0] cnt_dec;

    // Counter after one decrement, with the build-selected behaviour at zero.
    always_comb begin
        cnt_dec = cnt_q - 32'd1;
`ifdef HWLP_SATURATE_EN
        if (cnt_q == 32'd0) cnt_dec = 32'd0;
`else
        if (cnt_q == 32'd0) cnt_dec = HWLP_CNT_MAX;
`endif
    end

    // Next state: a counter write beats a same-cycle decrement and also
    // retires the in-flight flag; ID handoff clears before a new set.
    always_comb begin
        start_d  = start_q;
        end_d    = end_q;
        cnt_d    = cnt_q;
        dec_id_d = dec_id_q;
        if (we_start_i) start_d = start_data_i;
        if (we_end_i)   end_d   = end_data_i;
        if (we_cnt_i)   cnt_d   = cnt_data_i;
        else if (dec_i) cnt_d   = cnt_dec;
        if (we_cnt_i)        dec_id_d = 1'b0;
        else if (id_valid_i) dec_id_d = 1'b0;
        else if (dec_i)      dec_id_d = 1'b1;
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q  <= 32'd0;
            end_q    <= 32'd0;
            cnt_q    <= 32'd0;
            dec_id_q <= 1'b0;
        end else begin
            start_q  <= start_d;
            end_q    <= end_d;
            cnt_q    <= cnt_d;
            dec_id_q <= dec_id_d;
        end
    end

    assign start_o  = start_q;
    assign end_o    = end_q;
    assign cnt_o    = cnt_q;
    assign dec_id_o = dec_id_q;

endmodule

// File: rtl/riscv_hwloop_regs.sv
// Hardware-loop register file: N_REGS independent loop sets, each written by
// index and decremented by the loop controller. All outputs are registered.
// Build option: HWLP_SATURATE_EN (see riscv_hwloop_reg_slot).
module riscv_hwloop_regs
    import riscv_defines::*;
#(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 hwlp_start_data_i,
    input  logic [31:0]                 hwlp_end_data_i,
    input  logic [31:0]                 hwlp_cnt_data_i,
    input  logic [HWLP_WE_W-1:0]        hwlp_we_i,
    input  logic [N_REG_BITS-1:0]       hwlp_regid_i,
    input  logic [N_REGS-1:0]           hwlp_dec_cnt_i,
    input  logic                        id_valid_i,
    output logic [N_REGS-1:0][31:0]     hwlp_start_addr_o,
    output logic [N_REGS-1:0][31:0]     hwlp_end_addr_o,
    output logic [N_REGS-1:0][31:0]     hwlp_counter_o,
    output logic [N_REGS-1:0]           hwlp_dec_cnt_id_o
);

    // An out-of-range regid matches no slot, so the write is dropped.
    for (genvar i = 0; i < N_REGS; i++) begin : g_slot
        logic sel;
        assign sel = (hwlp_regid_i == N_REG_BITS'(i));

        riscv_hwloop_reg_slot u_slot (
            .clk          (clk),
            .rst          (rst),
            .we_start_i   (sel & hwlp_we_i[HWLP_WE_START]),
            .we_end_i     (sel & hwlp_we_i[HWLP_WE_END]),
            .we_cnt_i     (sel & hwlp_we_i[HWLP_WE_CNT]),
            .start_data_i (hwlp_start_data_i),
            .end_data_i   (hwlp_end_data_i),
            .cnt_data_i   (hwlp_cnt_data_i),
            .dec_i        (hwlp_dec_cnt_i[i]),
            .id_valid_i   (id_valid_i),
            .start_o      (hwlp_start_addr_o[i]),
            .end_o        (hwlp_end_addr_o[i]),
            .cnt_o        (hwlp_counter_o[i]),
            .dec_id_o     (hwlp_dec_cnt_id_o[i])
        );
    end

endmodule

// File: tb/tb_riscv_hwloop_regs.sv
// Self-checking bench for riscv_hwloop_regs: directed scenarios followed by
// random traffic, all checked against a behavioural model of the loop sets.
module tb_riscv_hwloop_regs;

`ifdef HWLP_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int NR = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [31:0]        s_d = '0, e_d = '0, c_d = '0;
    logic [2:0]         we = '0;
    logic [0:0]         regid = '0;
    logic [NR-1:0]      dec = '0;
    logic               idv = 1'b0;
    logic [NR-1:0][31:0] st_o, en_o, cn_o;
    logic [NR-1:0]      fl_o;

    int n_chk = 0;
    int n_bad = 0;

    // Reference state
    logic [31:0] m_st [NR];
    logic [31:0] m_en [NR];
    logic [31:0] m_cn [NR];
    bit          m_fl [NR];

    riscv_hwloop_regs #(.N_REGS(NR)) dut (
        .clk               (clk),
        .rst               (rst),
        .hwlp_start_data_i (s_d),
        .hwlp_end_data_i   (e_d),
        .hwlp_cnt_data_i   (c_d),
        .hwlp_we_i         (we),
        .hwlp_regid_i      (regid),
        .hwlp_dec_cnt_i    (dec),
        .id_valid_i        (idv),
        .hwlp_start_addr_o (st_o),
        .hwlp_end_addr_o   (en_o),
        .hwlp_counter_o    (cn_o),
        .hwlp_dec_cnt_id_o (fl_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] w, input int rid, input logic [31:0] s,
                         input logic [31:0] e, input logic [31:0] c,
                         input logic [NR-1:0] d, input logic v);
        we = w; regid = 1'(rid); s_d = s; e_d = e; c_d = c; dec = d; idv = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_st[i] = '0; m_en[i] = '0; m_cn[i] = '0; m_fl[i] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("%s_start%0d", tag, i), st_o[i], m_st[i]);
            chk($sformatf("%s_end%0d", tag, i), en_o[i], m_en[i]);
            chk($sformatf("%s_cnt%0d", tag, i), cn_o[i], m_cn[i]);
            chk($sformatf("%s_fl%0d", tag, i), 32'(fl_o[i]), 32'(m_fl[i]));
        end
    endtask

    // One clock: apply the loop-register rules to the model, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        for (int i = 0; i < NR; i++) begin
            bit hit;
            hit = (int'(regid) == i);
            if (hit && we[0]) m_st[i] = s_d;
            if (hit && we[1]) m_en[i] = e_d;
            if (hit && we[2]) begin
                m_cn[i] = c_d;
                m_fl[i] = 1'b0;
            end else begin
                if (dec[i]) begin
                    if (m_cn[i] == 0) m_cn[i] = SAT ? 32'd0 : 32'hFFFF_FFFF;
                    else              m_cn[i] = m_cn[i] - 1;
                end
                if (idv)         m_fl[i] = 1'b0;
                else if (dec[i]) m_fl[i] = 1'b1;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        // Reset dominates a pending write and clears everything.
        #2;
        check_all("rst0");
        rst = 1'b0;
        drive(3'b111, 0, 32'h40, 32'h80, 32'd6, 2'b00, 1'b0);
        step("pre");
        drive(3'b100, 0, 0, 0, 32'd5, 2'b01, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("rst_async");
        @(posedge clk); #1;
        check_all("rst_hold");
        rst = 1'b0;
        drive(3'b000, 0, 0, 0, 0, 2'b00, 1'b0);
        step("rst_after");
        chk("rst_cnt0_zero", cn_o[0], 32'd0);

        // First write after reset lands on the first edge.
        drive(3'b111, 1, 32'h100, 32'h120, 32'd3, 2'b00, 1'b0);
        step("wr1");
        chk("wr1_start", st_o[1], 32'h100);
        chk("wr1_end", en_o[1], 32'h120);
        chk("wr1_cnt", cn_o[1], 32'd3);
        chk("wr1_set0", cn_o[0], 32'd0);

        // Three decrements on set 1 with ID stalled.
        drive(3'b000, 0, 0, 0, 0, 2'b10, 1'b0);
        step("dec_a"); chk("dec_a_cnt", cn_o[1], 32'd2); chk("dec_a_fl", 32'(fl_o[1]), 32'd1);
        step("dec_b"); chk("dec_b_cnt", cn_o[1], 32'd1);
        step("dec_c"); chk("dec_c_cnt", cn_o[1], 32'd0);
        drive(3'b000, 0, 0, 0, 0, 2'b00, 1'b1);
        step("idv"); chk("idv_fl", 32'(fl_o[1]), 32'd0);

        // Counter write wins against a same-set decrement.
        drive(3'b100, 0, 0, 0, 32'd7, 2'b00, 1'b0);
        step("c7");
        drive(3'b100, 0, 0, 0, 32'd10, 2'b01, 1'b0);
        step("wr_vs_dec");
        chk("wr_vs_dec_cnt", cn_o[0], 32'd10);
        chk("wr_vs_dec_fl", 32'(fl_o[0]), 32'd0);

        // Decrement at zero.
        drive(3'b100, 0, 0, 0, 32'd0, 2'b00, 1'b0);
        step("z0");
        drive(3'b000, 0, 0, 0, 0, 2'b01, 1'b0);
        step("under");
        chk("under_cnt", cn_o[0], SAT ? 32'd0 : 32'hFFFF_FFFF);

        // Independent decrements on both sets.
        drive(3'b100, 0, 0, 0, 32'd4, 2'b00, 1'b0);
        step("c4");
        drive(3'b100, 1, 0, 0, 32'd9, 2'b00, 1'b0);
        step("c9");
        drive(3'b000, 0, 0, 0, 0, 2'b11, 1'b0);
        step("both");
        chk("both_cnt0", cn_o[0], 32'd3);
        chk("both_cnt1", cn_o[1], 32'd8);

        // Start/end-only write leaves counter and flag alone.
        drive(3'b011, 1, 32'hABC0, 32'hABF0, 32'd55, 2'b00, 1'b0);
        step("se_only");
        chk("se_only_cnt1", cn_o[1], 32'd8);

        // Random traffic; small counter values make underflow frequent.
        for (int k = 0; k < 400; k++) begin
            drive(3'($urandom), int'($urandom_range(0, 1)), $urandom, $urandom,
                  32'($urandom_range(0, 3)), 2'($urandom), 1'($urandom_range(0, 3) == 0));
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
